// File: rtl/panel_fb_pkg.sv
// Shared types and constants for the panel framebuffer write port.
// Holds the FIFO entry layout, FSM states and lane helpers.
package panel_fb_pkg;

    localparam int NUM_PANELS = 6;
    localparam int ADDR_W     = 13;
    localparam int PANEL_W    = 3;
    localparam int RAM_AW     = PANEL_W + ADDR_W;

    localparam int LANE_B = 0;
    localparam int LANE_G = 1;
    localparam int LANE_R = 2;

    localparam logic [2:0] LANES_FULL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_RMW_READ,
        ST_RMW_MERGE,
        ST_RMW_WRITE
    } fb_state_t;

    typedef struct packed {
        logic [NUM_PANELS-1:0] mask;
        logic [2:0]            lanes;
        logic [ADDR_W-1:0]     addr;
        logic [23:0]           wdat;
    } fb_entry_t;

    // Index of the lowest set bit; panels are served in ascending order.
    function automatic logic [PANEL_W-1:0] lowest_panel(
        input logic [NUM_PANELS-1:0] mask
    );
        logic [PANEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_PANELS - 1; i >= 0; i--) begin
            if (mask[i]) idx = PANEL_W'(i);
        end
        return idx;
    endfunction

    // Per-byte select between new pixel data and the current RAM word.
    function automatic logic [23:0] lane_merge(
        input logic [2:0]  lanes,
        input logic [23:0] wdat,
        input logic [23:0] old
    );
        logic [23:0] m;
        m = '0;
        for (int l = 0; l < 3; l++) begin
            m[l*8 +: 8] = lanes[l] ? wdat[l*8 +: 8] : old[l*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/panel_fb_fifo.sv
// Synchronous write FIFO for pending framebuffer writes.
// A push into a full FIFO is taken when a pop happens in the same cycle.
import panel_fb_pkg::*;

module panel_fb_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fb_entry_t                push_data,
    input  logic                     pop,
    output fb_entry_t                pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    fb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_LVL);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/panel_fb_write_port.sv
// Commits buffered ctrl-bus pixel writes into the shared panel RAM.
// Scanner reads always own the RAM port; writes use the idle cycles.
import panel_fb_pkg::*;

module panel_fb_write_port #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_PANELS-1:0] ctrl_en,
    input  logic [3:0]            ctrl_wr,
    input  logic [15:0]           ctrl_addr,
    input  logic [23:0]           ctrl_wdat,
    output logic                  ctrl_busy,
    output logic [15:0]           overflow_count,
    input  logic                  rd_req,
    input  logic [PANEL_W-1:0]    rd_panel,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_valid,
    output logic [23:0]           rd_data,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [23:0]           ram_wdat,
    input  logic [23:0]           ram_rdat
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BUSY_LVL = CNT_W'(FIFO_DEPTH - 2);

    logic [1:0]            rst_pipe;
    logic                  rst_n;
    logic                  push_req;
    fb_entry_t             push_entry;
    fb_entry_t             fifo_head;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  drop;
    fb_state_t             state;
    fb_state_t             state_n;
    fb_entry_t             work;
    fb_entry_t             work_n;
    logic [23:0]           merged;
    logic [PANEL_W-1:0]    panel;
    logic [NUM_PANELS-1:0] mask_left;
    logic                  wr_go;
    logic                  rd_go;
    logic [23:0]           wr_data;
    logic                  unused_bits;

    assign unused_bits = ^{ctrl_wr[3], ctrl_addr[15:ADDR_W]};

    // Reset asserts at once and releases two clocks after the pin rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n = rst_pipe[1];

    assign push_req = (|ctrl_en) && (|ctrl_wr[2:0]);
    assign push_entry = '{
        mask:  ctrl_en,
        lanes: ctrl_wr[2:0],
        addr:  ctrl_addr[ADDR_W-1:0],
        wdat:  ctrl_wdat
    };
    assign drop = push_req && fifo_full && !fifo_pop;

    panel_fb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (rst_n),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ctrl_busy = (fifo_count >= BUSY_LVL);
    assign rd_data   = rd_valid ? ram_rdat : 24'h0;

    // Dropped-write counter, saturating.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) overflow_count <= '0;
        else if (drop && overflow_count != 16'hFFFF)
            overflow_count <= overflow_count + 1'b1;
    end

    // Scanner read strobe delayed to line up with RAM read data.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) rd_valid <= 1'b0;
        else        rd_valid <= rd_req;
    end

    // FSM state, working entry and merge register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            work   <= '0;
            merged <= '0;
        end else begin
            state <= state_n;
            work  <= work_n;
            if (state == ST_RMW_MERGE)
                merged <= lane_merge(work.lanes, work.wdat, ram_rdat);
        end
    end

    // Next-state logic; everything but the merge stalls under a scanner read.
    always_comb begin
        state_n   = state;
        work_n    = work;
        fifo_pop  = 1'b0;
        wr_go     = 1'b0;
        rd_go     = 1'b0;
        wr_data   = work.wdat;
        panel     = lowest_panel(work.mask);
        mask_left = work.mask & ~(NUM_PANELS'(1) << panel);
        unique case (state)
            ST_IDLE: begin
                if (!rd_req && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    work_n   = fifo_head;
                    state_n  = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (!rd_req) begin
                    if (work.lanes == LANES_FULL) begin
                        wr_go = 1'b1;
                    end else begin
                        state_n = ST_RMW_READ;
                    end
                end
            end
            ST_RMW_READ: begin
                if (!rd_req) begin
                    rd_go   = 1'b1;
                    state_n = ST_RMW_MERGE;
                end
            end
            ST_RMW_MERGE: begin
                state_n = ST_RMW_WRITE;
            end
            ST_RMW_WRITE: begin
                if (!rd_req) begin
                    wr_go   = 1'b1;
                    wr_data = merged;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (wr_go) begin
            work_n.mask = mask_left;
            if (mask_left != '0) begin
                state_n = ST_DISPATCH;
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                work_n   = fifo_head;
                state_n  = ST_DISPATCH;
            end else begin
                state_n = ST_IDLE;
            end
        end
    end

    // RAM port mux: scanner first, then the FSM's write or read.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_wdat = '0;
        if (!rst_n) begin
            ram_we = 1'b0;
        end else if (rd_req) begin
            ram_addr = {rd_panel, rd_addr};
        end else if (wr_go) begin
            ram_we   = 1'b1;
            ram_addr = {panel, work.addr};
            ram_wdat = wr_data;
        end else if (rd_go) begin
            ram_addr = {panel, work.addr};
        end
    end

endmodule

// File: tb/tb_panel_fb_write_port.sv
// Directed bench for panel_fb_write_port with a behavioural RAM.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_panel_fb_write_port;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic        ctrl_busy;
    logic [15:0] overflow_count;
    logic        rd_req;
    logic [2:0]  rd_panel;
    logic [12:0] rd_addr;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [23:0] ram_wdat;
    logic [23:0] ram_rdat;

    logic [23:0] mem [65536];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [23:0] pre_data;

    int vectors    = 0;
    int miscompares = 0;

    panel_fb_write_port dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_en        (ctrl_en),
        .ctrl_wr        (ctrl_wr),
        .ctrl_addr      (ctrl_addr),
        .ctrl_wdat      (ctrl_wdat),
        .ctrl_busy      (ctrl_busy),
        .overflow_count (overflow_count),
        .rd_req         (rd_req),
        .rd_panel       (rd_panel),
        .rd_addr        (rd_addr),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_wdat       (ram_wdat),
        .ram_rdat       (ram_rdat)
    );

    always #5 clock = ~clock;

    // Single-port synchronous RAM, read-before-write, 1-cycle latency.
    always @(posedge clock) begin
        if (pre_we)      mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_wdat;
        ram_rdat <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [23:0] d);
        @(negedge clock);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    task automatic push(input logic [5:0] en, input logic [3:0] wr,
                        input logic [15:0] a, input logic [23:0] d);
        @(negedge clock);
        ctrl_en   = en;
        ctrl_wr   = wr;
        ctrl_addr = a;
        ctrl_wdat = d;
        @(negedge clock);
        ctrl_en   = '0;
        ctrl_wr   = '0;
    endtask

    task automatic wait_write(input string tag, input logic [15:0] a,
                              input logic [23:0] d, input int budget);
        int n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!ram_we && n < budget);
        check({tag, "_we"},   32'(ram_we),   32'd1);
        check({tag, "_addr"}, 32'(ram_addr), 32'(a));
        check({tag, "_wdat"}, 32'(ram_wdat), 32'(d));
    endtask

    task automatic expect_idle_port(input string tag, input int cycles);
        logic saw = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            #1;
            saw = saw | ram_we;
        end
        check(tag, 32'(saw), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        ctrl_en   = '0;
        ctrl_wr   = '0;
        ctrl_addr = '0;
        ctrl_wdat = '0;
        rd_req    = 1'b0;
        rd_panel  = '0;
        rd_addr   = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;

        preload(16'h4010, 24'h112233);
        preload(16'h2020, 24'hABCDEF);
        for (int i = 0; i < 5; i++)
            preload(16'h6100 + 16'(i), 24'h300000 + 24'(i));

        #1;
        check("rst_we",    32'(ram_we),         32'd0);
        check("rst_addr",  32'(ram_addr),       32'd0);
        check("rst_wdat",  32'(ram_wdat),       32'd0);
        check("rst_valid", 32'(rd_valid),       32'd0);
        check("rst_rdata", 32'(rd_data),        32'd0);
        check("rst_busy",  32'(ctrl_busy),      32'd0);
        check("rst_ovf",   32'(overflow_count), 32'd0);

        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Full-lane single-panel write.
        push(6'b000001, 4'b0111, 16'h0005, 24'h0000FF);
        wait_write("full", 16'h0005, 24'h0000FF, 3);

        // Partial write goes through read-modify-write.
        push(6'b000100, 4'b0001, 16'h0010, 24'h0000AA);
        wait_write("rmw", 16'h4010, 24'h1122AA, 6);

        // Broadcast to panels 0, 2 and 5 on back-to-back cycles.
        push(6'b100101, 4'b0111, 16'h0007, 24'h00FF00);
        wait_write("bc_p0", 16'h0007, 24'h00FF00, 4);
        @(negedge clock);
        #1;
        check("bc_p2_we",   32'(ram_we),   32'd1);
        check("bc_p2_addr", 32'(ram_addr), 32'h4007);
        @(negedge clock);
        #1;
        check("bc_p5_we",   32'(ram_we),   32'd1);
        check("bc_p5_addr", 32'(ram_addr), 32'hA007);
        @(negedge clock);
        #1;
        check("bc_done_we", 32'(ram_we),   32'd0);

        // Scanner reads stall a pending RMW for five cycles.
        push(6'b000010, 4'b0110, 16'h0020, 24'h123456);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i > 0) begin
                check("cont_valid", 32'(rd_valid), 32'd1);
                check("cont_rdata", 32'(rd_data),
                      32'h300000 + 32'(i - 1));
            end
            rd_req   = 1'b1;
            rd_panel = 3'd3;
            rd_addr  = 13'h100 + 13'(i);
            #1;
            check("cont_raddr", 32'(ram_addr), 32'h6100 + 32'(i));
            check("cont_we",    32'(ram_we),   32'd0);
        end
        @(negedge clock);
        rd_req = 1'b0;
        #1;
        check("cont_valid4", 32'(rd_valid), 32'd1);
        check("cont_rdata4", 32'(rd_data),  32'h300004);
        wait_write("cont_rmw", 16'h2020, 24'h1234EF, 6);

        // Overflow: scanner holds the port while 20 writes arrive.
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            rd_req    = 1'b1;
            rd_panel  = 3'd0;
            rd_addr   = 13'h0;
            ctrl_en   = 6'b000001;
            ctrl_wr   = 4'b0111;
            ctrl_addr = 16'h0200 + 16'(i);
            ctrl_wdat = 24'hA00000 + 24'(i);
        end
        @(negedge clock);
        ctrl_en = '0;
        ctrl_wr = '0;
        #1;
        check("ovf_count", 32'(overflow_count), 32'd4);
        check("ovf_busy",  32'(ctrl_busy),      32'd1);
        check("ovf_we",    32'(ram_we),         32'd0);
        @(negedge clock);
        rd_req = 1'b0;
        wait_write("drain0", 16'h0200, 24'hA00000, 3);
        for (int i = 1; i < 16; i++) begin
            @(negedge clock);
            #1;
            check("drain_we",   32'(ram_we),   32'd1);
            check("drain_addr", 32'(ram_addr), 32'h0200 + 32'(i));
            check("drain_wdat", 32'(ram_wdat), 32'hA00000 + 32'(i));
        end
        @(negedge clock);
        #1;
        check("drain_end_we", 32'(ram_we),    32'd0);
        check("drain_busy",   32'(ctrl_busy), 32'd0);

        // No lane enabled: nothing is queued.
        push(6'b000001, 4'b1000, 16'h0040, 24'h999999);
        expect_idle_port("nolane_we", 6);
        check("nolane_ovf", 32'(overflow_count), 32'd4);

        // Reset while the RMW sits in its merge cycle.
        push(6'b000001, 4'b0001, 16'h0030, 24'h000055);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_we",    32'(ram_we),         32'd0);
        check("mid_addr",  32'(ram_addr),       32'd0);
        check("mid_wdat",  32'(ram_wdat),       32'd0);
        check("mid_valid", 32'(rd_valid),       32'd0);
        check("mid_rdata", 32'(rd_data),        32'd0);
        check("mid_busy",  32'(ctrl_busy),      32'd0);
        check("mid_ovf",   32'(overflow_count), 32'd0);
        expect_idle_port("mid_hold_we", 2);
        reset = 1'b1;
        expect_idle_port("post_rst_we", 8);
        push(6'b000010, 4'b0111, 16'h0031, 24'h777777);
        wait_write("post_rst", 16'h2031, 24'h777777, 3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
